// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for the ILA sample buffer: drives the write side of a
// circular sample RAM through pre-trigger, post-trigger and done phases.
module ila_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int TRIG_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_val_i,
  input  logic [ADDR_W-1:0] post_cnt_i,
  input  logic              sample_en_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [ADDR_W:0]   count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;

  logic match;
  logic busy;
  logic wr_en;

  assign match = ((trig_i ^ trig_val_i) & trig_mask_i) == '0;
  assign busy  = (state_q == ST_PRE) || (state_q == ST_POST);
  // A control pulse owns its cycle: neither arm nor abort lets a sample land.
  assign wr_en = sample_en_i & busy & ~arm_i & ~abort_i;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block
    // leaves a signal unassigned, which would infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    post_d      = post_q;
    trig_addr_d = trig_addr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    done_d      = done_q;

    if (abort_i) begin
      // Abort keeps count and trigger address so the host can still inspect them.
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else if (arm_i) begin
      state_d     = ST_PRE;
      wr_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != COUNT_FULL) begin
        count_d = count_q + 1'b1;
      end

      unique case (state_q)
        ST_PRE: begin
          if (match) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            post_d      = post_cnt_i;
            if (post_cnt_i == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          post_d = post_q - 1'b1;
          if (post_q == POST_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      post_q      <= '0;
      trig_addr_q <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      post_q      <= post_d;
      trig_addr_q <= trig_addr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign wr_en_o     = wr_en;
  assign wr_addr_o   = wr_ptr_q;
  assign busy_o      = busy;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Self-checking bench for ila_capture_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural capture model.
module tb_ila_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int TRIG_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              arst_i;
  logic              arm_i, abort_i, sample_en_i;
  logic [TRIG_W-1:0] trig_i, trig_mask_i, trig_val_i;
  logic [ADDR_W-1:0] post_cnt_i;
  logic              wr_en_o, busy_o, triggered_o, done_o;
  logic [ADDR_W-1:0] wr_addr_o, trig_addr_o;
  logic [ADDR_W:0]   count_o;

  ila_capture_ctrl #(.ADDR_W(ADDR_W), .TRIG_W(TRIG_W)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_i(trig_i), .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i),
    .post_cnt_i(post_cnt_i), .sample_en_i(sample_en_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .busy_o(busy_o),
    .triggered_o(triggered_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [ADDR_W-1:0] wr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a capture is "active" until its post-trigger quota is used.
  bit m_active, m_trig, m_done;
  int m_left, m_ptr, m_count, m_trig_addr;

  task automatic m_reset();
    m_active = 0; m_trig = 0; m_done = 0;
    m_left = 0; m_ptr = 0; m_count = 0; m_trig_addr = 0;
  endtask

  function automatic bit m_match(input logic [TRIG_W-1:0] t, m, v);
    for (int i = 0; i < TRIG_W; i++)
      if (m[i] && (t[i] != v[i])) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_i) begin
    if (!arst_i) begin
      if (abort_i) begin
        m_active = 0; m_trig = 0; m_done = 0;
      end else if (arm_i) begin
        m_active = 1; m_trig = 0; m_done = 0; m_ptr = 0; m_count = 0;
      end else if (m_active && sample_en_i) begin
        if (m_trig) begin
          m_left = m_left - 1;
        end else if (m_match(trig_i, trig_mask_i, trig_val_i)) begin
          m_trig = 1; m_trig_addr = m_ptr; m_left = int'(post_cnt_i);
        end
        m_ptr   = (m_ptr + 1) % DEPTH;
        m_count = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
        if (m_trig && m_left == 0) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  // Single compare process, half a cycle away from the active edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("wr_en",     32'(wr_en_o),     32'(sample_en_i && m_active && !arm_i && !abort_i));
      check("wr_addr",   32'(wr_addr_o),   32'(m_ptr));
      check("busy",      32'(busy_o),      32'(m_active));
      check("triggered", 32'(triggered_o), 32'(m_trig));
      check("done",      32'(done_o),      32'(m_done));
      check("trig_addr", 32'(trig_addr_o), 32'(m_trig_addr));
      check("count",     32'(count_o),     32'(m_count));
    end
    if (wr_en_o) wr_log.push_back(wr_addr_o);
  end

  task automatic tick(input logic arm, input logic abort, input logic [TRIG_W-1:0] t, input logic sen);
    arm_i = arm; abort_i = abort; trig_i = t; sample_en_i = sen;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [TRIG_W-1:0] m, input logic [TRIG_W-1:0] v, input logic [ADDR_W-1:0] p);
    trig_mask_i = m; trig_val_i = v; post_cnt_i = p;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},  32'(wr_en_o),     32'd0);
    check({tag, "_addr"},   32'(wr_addr_o),   32'd0);
    check({tag, "_busy"},   32'(busy_o),      32'd0);
    check({tag, "_trig"},   32'(triggered_o), 32'd0);
    check({tag, "_done"},   32'(done_o),      32'd0);
    check({tag, "_taddr"},  32'(trig_addr_o), 32'd0);
    check({tag, "_count"},  32'(count_o),     32'd0);
  endtask

  initial begin
    arst_i = 1'b1; arm_i = 0; abort_i = 0; trig_i = '0; sample_en_i = 1'b1;
    cfg(4'hF, 4'hA, 4'd3);
    m_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    chk_en = 1'b1;

    // Basic post-trigger capture.
    tick(1, 0, 4'h0, 1);
    wr_log.delete();
    repeat (5) tick(0, 0, 4'h0, 1);
    tick(0, 0, 4'hA, 1);
    repeat (5) tick(0, 0, 4'h0, 1);
    check("t1_writes",    32'(wr_log.size()), 32'd9);
    check("t1_first",     32'(wr_log[0]),     32'd0);
    check("t1_last",      32'(wr_log[8]),     32'd8);
    check("t1_trig_addr", 32'(trig_addr_o),   32'd5);
    check("t1_done",      32'(done_o),        32'd1);
    check("t1_count",     32'(count_o),       32'd9);
    check("t1_wr_off",    32'(wr_en_o),       32'd0);

    // Wrap and saturation.
    cfg(4'hF, 4'hA, 4'd2);
    tick(1, 0, 4'h0, 1);
    wr_log.delete();
    repeat (20) tick(0, 0, 4'h0, 1);
    tick(0, 0, 4'hA, 1);
    repeat (4) tick(0, 0, 4'h0, 1);
    check("t2_writes",    32'(wr_log.size()), 32'd23);
    check("t2_wrap_hi",   32'(wr_log[15]),    32'd15);
    check("t2_wrap_lo",   32'(wr_log[16]),    32'd0);
    check("t2_trig_addr", 32'(trig_addr_o),   32'd4);
    check("t2_count",     32'(count_o),       32'd16);
    check("t2_final",     32'(wr_addr_o),     32'd7);
    check("t2_done",      32'(done_o),        32'd1);

    // All-zero mask matches the first sample.
    cfg(4'h0, 4'h5, 4'd0);
    tick(1, 0, 4'h3, 1);
    wr_log.delete();
    repeat (3) tick(0, 0, 4'h9, 1);
    check("t3_writes",    32'(wr_log.size()), 32'd1);
    check("t3_addr",      32'(wr_log[0]),     32'd0);
    check("t3_trig",      32'(triggered_o),   32'd1);
    check("t3_done",      32'(done_o),        32'd1);
    check("t3_trig_addr", 32'(trig_addr_o),   32'd0);

    // Abort mid-POST.
    cfg(4'hF, 4'hA, 4'd5);
    tick(1, 0, 4'h0, 1);
    wr_log.delete();
    repeat (2) tick(0, 0, 4'h0, 1);
    tick(0, 0, 4'hA, 1);
    repeat (2) tick(0, 0, 4'h0, 1);
    tick(0, 1, 4'h0, 1);
    repeat (3) tick(0, 0, 4'hA, 1);
    check("t4_writes",    32'(wr_log.size()), 32'd5);
    check("t4_busy",      32'(busy_o),        32'd0);
    check("t4_done",      32'(done_o),        32'd0);
    check("t4_count",     32'(count_o),       32'd5);
    check("t4_trig_addr", 32'(trig_addr_o),   32'd2);

    // Arm and abort together: abort wins.
    wr_log.delete();
    tick(1, 1, 4'h0, 1);
    repeat (2) tick(0, 0, 4'h0, 1);
    check("t5_busy",   32'(busy_o),        32'd0);
    check("t5_writes", 32'(wr_log.size()), 32'd0);

    // Arm in DONE restarts cleanly.
    cfg(4'h0, 4'h0, 4'd0);
    tick(1, 0, 4'h0, 1);
    repeat (3) tick(0, 0, 4'h0, 1);
    check("t6_pre_done", 32'(done_o),    32'd1);
    tick(1, 0, 4'h0, 1);
    check("t6_busy",     32'(busy_o),    32'd1);
    check("t6_count",    32'(count_o),   32'd0);
    check("t6_addr",     32'(wr_addr_o), 32'd0);
    check("t6_done",     32'(done_o),    32'd0);

    // Gated strobe: only strobed cycles write or count down.
    cfg(4'hF, 4'h3, 4'd3);
    tick(1, 0, 4'h0, 0);
    wr_log.delete();
    for (int i = 0; i < 14; i++) tick(0, 0, (i == 5) ? 4'h3 : 4'h0, logic'(i % 2));
    check("t7_writes",    32'(wr_log.size()), 32'd6);
    check("t7_trig_addr", 32'(trig_addr_o),   32'd2);
    check("t7_count",     32'(count_o),       32'd6);
    check("t7_done",      32'(done_o),        32'd1);

    // Async reset mid-capture, observed before any clock edge.
    cfg(4'hF, 4'hA, 4'd4);
    tick(1, 0, 4'h0, 1);
    repeat (3) tick(0, 0, 4'h0, 1);
    tick(0, 0, 4'hA, 1);
    tick(0, 0, 4'h0, 1);
    #2;
    arst_i = 1'b1;
    m_reset();
    #1;
    check_all_zero("arst");
    tick(0, 0, 4'h0, 1);
    arst_i = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic a, ab;
      a  = ($urandom_range(0, 29) == 0);
      ab = ($urandom_range(0, 59) == 0);
      if (a) cfg(4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1) * 4'hC),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)));
      tick(a, ab, 4'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
